// File: rtl/dcpu16_marb.sv
// dcpu16_marb: three-master arbiter (F, G, X) onto one sync single-port RAM.
// Ports: f_/g_/x_ simplified Wishbone slaves; m_ RAM master; clk, rst (sync high).
module dcpu16_marb #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int XWAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] f_adr,
  input  logic [DW-1:0] f_dto,
  input  logic          f_stb,
  input  logic          f_wre,
  output logic [DW-1:0] f_dti,
  output logic          f_ack,
  input  logic [AW-1:0] g_adr,
  input  logic [DW-1:0] g_dto,
  input  logic          g_stb,
  input  logic          g_wre,
  output logic [DW-1:0] g_dti,
  output logic          g_ack,
  input  logic [AW-1:0] x_adr,
  input  logic [DW-1:0] x_dto,
  input  logic          x_stb,
  input  logic          x_wre,
  output logic [DW-1:0] x_dti,
  output logic          x_ack,
  output logic [AW-1:0] m_adr,
  output logic [DW-1:0] m_dto,
  output logic          m_ena,
  output logic          m_wre,
  input  logic [DW-1:0] m_dti
);

  localparam logic [3:0] XW = 4'(XWAIT);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_F,
    GNT_G,
    GNT_X
  } gnt_e;

  gnt_e       gnt_q;
  gnt_e       gnt_d;
  logic [3:0] xcnt_q;
  logic [3:0] xcnt_d;
  logic       fe;
  logic       ge;
  logic       xe;
  logic       xpri;

  // The ack registers are the decoded previous-cycle grant.
  assign f_ack = (gnt_q == GNT_F);
  assign g_ack = (gnt_q == GNT_G);
  assign x_ack = (gnt_q == GNT_X);

  // A master in its ack cycle cannot be re-granted.
  assign fe   = f_stb & ~f_ack;
  assign ge   = g_stb & ~g_ack;
  assign xe   = x_stb & ~x_ack;
  assign xpri = xe & (xcnt_q == XW);

  assign f_dti = m_dti;
  assign g_dti = m_dti;
  assign x_dti = m_dti;

  always_comb begin
    gnt_d = GNT_NONE;
    if (rst)       gnt_d = GNT_NONE;
    else if (xpri) gnt_d = GNT_X;
    else if (fe)   gnt_d = GNT_F;
    else if (ge)   gnt_d = GNT_G;
    else if (xe)   gnt_d = GNT_X;
  end

  // Starvation counter for X; saturates at XWAIT.
  always_comb begin
    xcnt_d = xcnt_q;
    if (!x_stb || gnt_d == GNT_X)
      xcnt_d = '0;
    else if (xe && xcnt_q != XW)
      xcnt_d = xcnt_q + 4'd1;
  end

  always_comb begin
    m_ena = 1'b0;
    m_wre = 1'b0;
    m_adr = f_adr;
    m_dto = f_dto;
    unique case (gnt_d)
      GNT_F: begin
        m_ena = 1'b1;
        m_wre = f_wre;
      end
      GNT_G: begin
        m_ena = 1'b1;
        m_wre = g_wre;
        m_adr = g_adr;
        m_dto = g_dto;
      end
      GNT_X: begin
        m_ena = 1'b1;
        m_wre = x_wre;
        m_adr = x_adr;
        m_dto = x_dto;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q  <= GNT_NONE;
      xcnt_q <= '0;
    end else begin
      gnt_q  <= gnt_d;
      xcnt_q <= xcnt_d;
    end
  end

endmodule
